// File: rtl/bcd_time_pkg.sv
// Shared constants and helpers for the cascaded BCD time counter.
// Holds the BCD digit/field widths, the modulo-60 field maximum, a converter
// from a decimal modulus to its BCD maximum, and a BCD digit validity check.
package bcd_time_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned FIELD_W = 8;

   // Largest value of a seconds/minutes field.
   localparam logic [FIELD_W-1:0] FIELD_MAX = 8'h59;

   // Decimal modulus -> BCD encoding of (modulus - 1); modulus is 2..100.
   function automatic logic [FIELD_W-1:0] to_bcd_max(input int unsigned modulus);
      int unsigned m;
      m = modulus - 1;
      return {DIGIT_W'(m / 10), DIGIT_W'(m % 10)};
   endfunction

   // True when a nibble is a legal decimal digit.
   function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/bcd_time_counter_field.sv
// One two-digit BCD field of the cascaded counter (purely combinational).
// Ports:
//   value     - current field value (tens in the high nibble)
//   step      - apply one step this cycle (count enable or carry/borrow in)
//   up        - 1 = increment, 0 = decrement
//   max_bcd   - BCD maximum of this field (59 or TOP_MOD-1)
//   next_val  - value after the optional step
//   carry_out - field wrapped (max->0 up, 0->max down); only when step is high
module bcd_field
   import bcd_time_pkg::*;
(
   input  logic [FIELD_W-1:0] value,
   input  logic               step,
   input  logic               up,
   input  logic [FIELD_W-1:0] max_bcd,
   output logic [FIELD_W-1:0] next_val,
   output logic               carry_out
);

   logic [DIGIT_W-1:0] tens;
   logic [DIGIT_W-1:0] units;

   assign tens  = value[FIELD_W-1:DIGIT_W];
   assign units = value[DIGIT_W-1:0];

   // Step logic: field wrap is checked before the units/tens digit roll.
   always_comb begin
      next_val  = value;
      carry_out = 1'b0;
      if (step) begin
         if (up) begin
            if (value == max_bcd) begin
               next_val  = '0;
               carry_out = 1'b1;
            end else if (units == DIGIT_W'(9)) begin
               next_val = {tens + DIGIT_W'(1), DIGIT_W'(0)};
            end else begin
               next_val = {tens, units + DIGIT_W'(1)};
            end
         end else begin
            if (value == '0) begin
               next_val  = max_bcd;
               carry_out = 1'b1;
            end else if (units == DIGIT_W'(0)) begin
               next_val = {tens - DIGIT_W'(1), DIGIT_W'(9)};
            end else begin
               next_val = {tens, units - DIGIT_W'(1)};
            end
         end
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// Parametrised BCD time-of-day / stopwatch counter made of cascaded two-digit
// fields. Lower fields count modulo 60, the top field modulo TOP_MOD.
// Optional feature macro: BCD_ALARM_EN builds the alarm comparator; without
// it alarm is tied low and alarm_val is ignored.
// Ports:
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   en, up       - count enable, direction (1 = up)
//   load         - synchronous load of load_val (validated)
//   load_val     - BCD load value, field i at bits [8i+7:8i]
//   alarm_val    - BCD alarm compare value
//   count        - current BCD count
//   wrap         - one-cycle pulse on full-counter wrap
//   load_err     - one-cycle pulse on a rejected load
//   alarm        - one-cycle pulse when count becomes alarm_val
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter int unsigned FIELDS  = 3,
   parameter int unsigned TOP_MOD = 24
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      up,
   input  logic                      load,
   input  logic [FIELD_W*FIELDS-1:0] load_val,
   input  logic [FIELD_W*FIELDS-1:0] alarm_val,
   output logic [FIELD_W*FIELDS-1:0] count,
   output logic                      wrap,
   output logic                      load_err,
   output logic                      alarm
);

   localparam int unsigned         CW      = FIELD_W * FIELDS;
   localparam logic [FIELD_W-1:0]  TOP_MAX = to_bcd_max(TOP_MOD);

   logic [FIELDS:0] carry;
   logic [CW-1:0]   stepped;
   logic            load_ok;
   logic [CW-1:0]   count_d;
   logic            wrap_d;
   logic            load_err_d;

   // The enable is the step into field 0; each field's wrap steps the next.
   assign carry[0] = en;

   for (genvar g = 0; g < int'(FIELDS); g++) begin : g_field
      localparam logic [FIELD_W-1:0] MAX = (g == int'(FIELDS) - 1) ? TOP_MAX : FIELD_MAX;
      bcd_field u_field (
         .value     (count[g*FIELD_W +: FIELD_W]),
         .step      (carry[g]),
         .up        (up),
         .max_bcd   (MAX),
         .next_val  (stepped[g*FIELD_W +: FIELD_W]),
         .carry_out (carry[g+1])
      );
   end

   // Load validation: legal digits, and each field within its own range.
   // With legal digits, a plain compare of BCD bytes matches decimal order.
   always_comb begin
      logic [FIELD_W-1:0] fld;
      fld     = '0;
      load_ok = 1'b1;
      for (int i = 0; i < int'(FIELDS); i++) begin
         fld = load_val[i*FIELD_W +: FIELD_W];
         if (!digit_ok(fld[FIELD_W-1:DIGIT_W]) || !digit_ok(fld[DIGIT_W-1:0])) begin
            load_ok = 1'b0;
         end
         if (i == int'(FIELDS) - 1) begin
            if (fld > TOP_MAX) load_ok = 1'b0;
         end else if (fld > FIELD_MAX) begin
            load_ok = 1'b0;
         end
      end
   end

   // Next count and flags: load beats enable; a rejected load also blocks en.
   always_comb begin
      count_d    = count;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if (load_ok) count_d = load_val;
         else         load_err_d = 1'b1;
      end else if (en) begin
         count_d = stepped;
         wrap_d  = carry[FIELDS];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         count    <= count_d;
         wrap     <= wrap_d;
         load_err <= load_err_d;
      end
   end

`ifdef BCD_ALARM_EN
   logic alarm_d;

   // Fire only on arrival at the alarm value, not while holding there.
   assign alarm_d = (count_d == alarm_val) && (count != alarm_val);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) alarm <= 1'b0;
      else       alarm <= alarm_d;
   end
`else
   logic unused_alarm_val;
   assign unused_alarm_val = ^alarm_val;
   assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter: a 3-field/mod-24 main
// instance, a 2-field/mod-60 instance for the full MM:SS run, and a
// 1-field/mod-6 instance for the single-digit top field.
module tb_bcd_time_counter;

`ifdef BCD_ALARM_EN
   localparam bit ALARM_ON = 1'b1;
`else
   localparam bit ALARM_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        en, up, load;
   logic [23:0] load_val, alarm_val, count;
   logic        wrap, load_err, alarm;

   logic        en2;
   logic [15:0] count2;
   logic        wrap2, load_err2, alarm2;

   logic        en3, up3;
   logic [7:0]  count3;
   logic        wrap3, load_err3, alarm3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bcd_time_counter #(.FIELDS(3), .TOP_MOD(24)) dut (
      .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
      .load_val(load_val), .alarm_val(alarm_val), .count(count),
      .wrap(wrap), .load_err(load_err), .alarm(alarm)
   );

   bcd_time_counter #(.FIELDS(2), .TOP_MOD(60)) dut2 (
      .clock(clock), .reset(reset), .en(en2), .up(1'b1), .load(1'b0),
      .load_val(16'h0000), .alarm_val(16'h0000), .count(count2),
      .wrap(wrap2), .load_err(load_err2), .alarm(alarm2)
   );

   bcd_time_counter #(.FIELDS(1), .TOP_MOD(6)) dut3 (
      .clock(clock), .reset(reset), .en(en3), .up(up3), .load(1'b0),
      .load_val(8'h00), .alarm_val(8'h00), .count(count3),
      .wrap(wrap3), .load_err(load_err3), .alarm(alarm3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
      load_val = '0; alarm_val = 24'h999999;
      en2 = 1'b0; en3 = 1'b0; up3 = 1'b1;
      #1;
      check("reset_count",    count,    32'h0);
      check("reset_wrap",     wrap,     32'h0);
      check("reset_load_err", load_err, 32'h0);
      check("reset_alarm",    alarm,    32'h0);
      tick(); tick();
      reset = 1'b0;

      // Load top-of-day then wrap up, then wrap back down.
      load = 1'b1; load_val = 24'h235959;
      tick();
      check("load_235959",      count,    32'h235959);
      check("load_ok_no_err",   load_err, 32'h0);
      check("load_no_wrap",     wrap,     32'h0);
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      check("up_wrap_count", count, 32'h000000);
      check("up_wrap_pulse", wrap,  32'h1);
      en = 1'b0;
      tick();
      check("wrap_one_cycle", wrap,  32'h0);
      check("hold_count",     count, 32'h000000);
      en = 1'b1; up = 1'b0;
      tick();
      check("down_wrap_count", count, 32'h235959);
      check("down_wrap_pulse", wrap,  32'h1);
      en = 1'b0;
      tick();

      // Rejected loads: bad minutes field, then top field out of range with en.
      load = 1'b1; load_val = 24'h126099;
      tick();
      check("bad_min_err",   load_err, 32'h1);
      check("bad_min_count", count,    32'h235959);
      load = 1'b0;
      tick();
      check("err_one_cycle", load_err, 32'h0);
      load = 1'b1; load_val = 24'h240000; en = 1'b1; up = 1'b1;
      tick();
      check("bad_top_err",   load_err, 32'h1);
      check("bad_top_count", count,    32'h235959);
      check("bad_top_nowrap", wrap,    32'h0);

      // Load wins over enable.
      load_val = 24'h010203;
      tick();
      check("load_over_en",   count,    32'h010203);
      check("load_over_flag", wrap | load_err, 32'h0);

      // Direction changes with no dead cycle, plus digit borrows.
      load = 1'b0; up = 1'b0;
      tick();
      check("down_step", count, 32'h010202);
      up = 1'b1;
      tick();
      check("dir_change_up", count, 32'h010203);
      en = 1'b0; load = 1'b1; load_val = 24'h010000;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      check("borrow_chain", count, 32'h005959);
      check("borrow_nowrap", wrap, 32'h0);

      // Alarm on arrival at 00:10:00 only.
      en = 1'b0; alarm_val = 24'h001000; load = 1'b1; load_val = 24'h000958;
      tick();
      check("alarm_load_no", alarm, 32'h0);
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      check("alarm_959",   count, 32'h000959);
      check("alarm_early", alarm, 32'h0);
      tick();
      check("alarm_1000",  count, 32'h001000);
      check("alarm_fire",  alarm, {31'h0, ALARM_ON});
      en = 1'b0;
      tick();
      check("alarm_hold", alarm, 32'h0);
      alarm_val = 24'h999999;

      // Asynchronous reset mid-count.
      load = 1'b1; load_val = 24'h051233;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      check("pre_reset_count", count, 32'h051234);
      #2 reset = 1'b1;
      #1;
      check("async_rst_count", count, 32'h0);
      check("async_rst_flags", {wrap, load_err, alarm}, 32'h0);
      #1 reset = 1'b0;
      tick();
      check("resume_after_rst", count, 32'h000001);
      en = 1'b0;

      // Single-digit top field: 00 <-> 05.
      en3 = 1'b1; up3 = 1'b0;
      tick();
      check("mod6_down",      count3, 32'h05);
      check("mod6_down_wrap", wrap3,  32'h1);
      up3 = 1'b1;
      tick();
      check("mod6_up",        count3, 32'h00);
      check("mod6_up_wrap",   wrap3,  32'h1);
      en3 = 1'b0;

      // Full MM:SS run.
      en2 = 1'b1;
      for (int i = 0; i < 3599; i++) begin
         @(posedge clock);
      end
      #1;
      check("mmss_5959",      count2, 32'h5959);
      check("mmss_no_wrap",   wrap2,  32'h0);
      tick();
      check("mmss_wrap_count", count2, 32'h0000);
      check("mmss_wrap_pulse", wrap2,  32'h1);
      tick();
      check("mmss_after",      count2, 32'h0001);
      check("mmss_wrap_clear", wrap2,  32'h0);
      en2 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
